// File: rtl/alu_writeback_seq.sv
// Tags ALU issues through two stages and writes results back (GP, or LO then HI).
// Optional ALU_WB_FLAGS_EN adds zero/negative flags updated on every write.
module alu_writeback_seq (
    input  logic        clk,
    input  logic        clear,
    input  logic        issue_valid,
    input  logic [4:0]  issue_opcode,
    input  logic [3:0]  issue_rd,
    output logic        issue_ready,
    input  logic [63:0] C_reg,
    output logic        wb_we,
    output logic [1:0]  wb_sel,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data
`ifdef ALU_WB_FLAGS_EN
    ,
    output logic        flag_z,
    output logic        flag_n
`endif
);

    typedef enum logic {IDLE, WR_HI} state_t;

    localparam logic [1:0] SEL_GP = 2'b00;
    localparam logic [1:0] SEL_LO = 2'b01;
    localparam logic [1:0] SEL_HI = 2'b10;

    state_t      state_q, state_d;
    logic        t1_vld_q, t1_vld_d;
    logic        t1_md_q, t1_md_d;
    logic [3:0]  t1_rd_q, t1_rd_d;
    logic        t2_vld_q;
    logic        t2_md_q;
    logic [3:0]  t2_rd_q;
    logic [31:0] hold_q, hold_d;
    logic        issue_ready_q, issue_ready_d;
    logic        wb_we_q, wb_we_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic [3:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic accept;
    logic op_ok;
    logic op_md;

    assign accept = issue_valid && issue_ready_q;

    always_comb begin
        op_ok = 1'b0;
        case (issue_opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010,
            5'b01011, 5'b01111, 5'b10000, 5'b10001,
            5'b10010: op_ok = 1'b1;
            default:  op_ok = 1'b0;
        endcase
        op_md = (issue_opcode == 5'b10000) || (issue_opcode == 5'b01111);
    end

    always_comb begin
        t1_vld_d = accept && op_ok;
        t1_md_d  = op_md;
        t1_rd_d  = issue_rd;
        // Stall one cycle after MUL/DIV so the next result lands after the HI beat
        issue_ready_d = !(accept && op_md);
    end

    always_comb begin
        state_d   = IDLE;
        hold_d    = hold_q;
        wb_we_d   = 1'b0;
        wb_sel_d  = wb_sel_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (state_q == WR_HI) begin
            wb_we_d   = 1'b1;
            wb_sel_d  = SEL_HI;
            wb_data_d = hold_q;
        end else if (t2_vld_q) begin
            wb_we_d   = 1'b1;
            wb_data_d = C_reg[31:0];
            if (t2_md_q) begin
                wb_sel_d = SEL_LO;
                hold_d   = C_reg[63:32];
                state_d  = WR_HI;
            end else begin
                wb_sel_d  = SEL_GP;
                wb_addr_d = t2_rd_q;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q       <= IDLE;
            t1_vld_q      <= 1'b0;
            t1_md_q       <= 1'b0;
            t1_rd_q       <= 4'd0;
            t2_vld_q      <= 1'b0;
            t2_md_q       <= 1'b0;
            t2_rd_q       <= 4'd0;
            hold_q        <= 32'd0;
            issue_ready_q <= 1'b1;
            wb_we_q       <= 1'b0;
            wb_sel_q      <= SEL_GP;
            wb_addr_q     <= 4'd0;
            wb_data_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            t1_vld_q      <= t1_vld_d;
            t1_md_q       <= t1_md_d;
            t1_rd_q       <= t1_rd_d;
            t2_vld_q      <= t1_vld_q;
            t2_md_q       <= t1_md_q;
            t2_rd_q       <= t1_rd_q;
            hold_q        <= hold_d;
            issue_ready_q <= issue_ready_d;
            wb_we_q       <= wb_we_d;
            wb_sel_q      <= wb_sel_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
        end
    end

    assign issue_ready = issue_ready_q;
    assign wb_we       = wb_we_q;
    assign wb_sel      = wb_sel_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;

`ifdef ALU_WB_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_n_q, flag_n_d;
    logic lo_zero_q, lo_zero_d;

    // HI-beat zero flag covers the whole 64-bit product/quotient
    always_comb begin
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        lo_zero_d = lo_zero_q;
        if (state_q == WR_HI) begin
            flag_n_d = hold_q[31];
            flag_z_d = (hold_q == 32'd0) && lo_zero_q;
        end else if (t2_vld_q) begin
            flag_z_d  = (C_reg[31:0] == 32'd0);
            flag_n_d  = C_reg[31];
            lo_zero_d = (C_reg[31:0] == 32'd0);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            lo_zero_q <= 1'b0;
        end else begin
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
            lo_zero_q <= lo_zero_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_writeback_seq.sv
// Scoreboard bench for alu_writeback_seq: driver predicts writes, negedge monitor checks.
module tb_alu_writeback_seq;

    logic        clk = 1'b0;
    logic        clear;
    logic        issue_valid;
    logic [4:0]  issue_opcode;
    logic [3:0]  issue_rd;
    logic        issue_ready;
    logic [63:0] C_reg;
    logic        wb_we;
    logic [1:0]  wb_sel;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    alu_writeback_seq dut (
        .clk          (clk),
        .clear        (clear),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .C_reg        (C_reg),
        .wb_we        (wb_we),
        .wb_sel       (wb_sel),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  addr;
        logic [31:0] data;
        int          at_edge;
    } exp_t;

    exp_t        q[$];
    logic [63:0] c_due[int];
    int          checks = 0;
    int          errors = 0;
    int          ecount = 0;
    bit          ready_m = 1'b1;
    logic [3:0]  last_addr = 4'd0;
    bit          mon_en = 1'b0;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_MUL = 5'b10000;

    function automatic bit op_valid(input logic [4:0] op);
        logic [4:0] ops [13];
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    task automatic drive_c();
        if (c_due.exists(ecount)) C_reg = c_due[ecount];
        else C_reg = {$urandom, $urandom};
    endtask

    // One cycle of stimulus; the model decides acceptance from its own ready
    task automatic step(input logic v, input logic [4:0] op,
                        input logic [3:0] rd, input logic [63:0] r,
                        output bit acc);
        exp_t e;
        issue_valid  = v;
        issue_opcode = op;
        issue_rd     = rd;
        @(posedge clk);
        ecount++;
        acc = v && ready_m;
        if (acc && op_valid(op)) begin
            c_due[ecount + 1] = r;
            if (op_wide(op)) begin
                e = '{2'b01, last_addr, r[31:0], ecount + 2};
                q.push_back(e);
                e = '{2'b10, last_addr, r[63:32], ecount + 3};
                q.push_back(e);
            end else begin
                e = '{2'b00, rd, r[31:0], ecount + 2};
                q.push_back(e);
                last_addr = rd;
            end
        end
        ready_m = !(acc && op_wide(op));
        #1;
        issue_valid = 1'b0;
        drive_c();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 4'd0, 64'd0, a);
    endtask

    task automatic issue_hold(input logic [4:0] op, input logic [3:0] rd,
                              input logic [63:0] r);
        bit a;
        int tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 4) begin
            step(1'b1, op, rd, r, a);
            tries++;
        end
        checks++;
        if (!a) begin
            errors++;
            $display("FAIL hold_accept: not accepted after %0d cycles, required acceptance", tries);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (wb_we !== 1'b0 || wb_sel !== 2'b00 || wb_addr !== 4'd0 ||
            wb_data !== 32'd0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: we=%b sel=%b addr=%h data=%h rdy=%b, required 0 00 0 0 1",
                     name, wb_we, wb_sel, wb_addr, wb_data, issue_ready);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        #2;
        clear = 1'b1;
        q.delete();
        #1;
        check_reset("clear_mid");
        @(posedge clk);
        ecount++;
        #1;
        clear = 1'b0;
        ready_m = 1'b1;
        last_addr = 4'd0;
        check_reset("clear_release");
        drive_c();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (issue_ready !== ready_m) begin
                errors++;
                $display("FAIL ready@%0d: got %b, required %b", ecount, issue_ready, ready_m);
            end
            while (q.size() > 0 && q[0].at_edge < ecount) begin
                checks++;
                errors++;
                $display("FAIL missed_write@%0d: got none, required sel=%b data=%h",
                         q[0].at_edge, q[0].sel, q[0].data);
                void'(q.pop_front());
            end
            if (wb_we === 1'b1) begin
                checks++;
                if (q.size() == 0 || q[0].at_edge != ecount) begin
                    errors++;
                    $display("FAIL unexpected_write@%0d: got sel=%b data=%h, required no write",
                             ecount, wb_sel, wb_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (wb_sel !== e.sel || wb_addr !== e.addr || wb_data !== e.data) begin
                        errors++;
                        $display("FAIL write@%0d: got sel=%b addr=%h data=%h, required sel=%b addr=%h data=%h",
                                 ecount, wb_sel, wb_addr, wb_data, e.sel, e.addr, e.data);
                    end
                end
            end else if (wb_we !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL we_x@%0d: got %b, required 0 or 1", ecount, wb_we);
            end
        end
    end

    initial begin
        bit a;
        logic [4:0]  op;
        logic [63:0] r;
        clear = 1'b0;
        issue_valid = 1'b0;
        issue_opcode = 5'd0;
        issue_rd = 4'd0;
        C_reg = 64'd0;
        #1 clear = 1'b1;
        #2 check_reset("reset");
        @(posedge clk);
        ecount++;
        #1 clear = 1'b0;
        check_reset("reset_release");
        mon_en = 1'b1;
        idle(2);

        step(1'b1, OP_ADD, 4'd5, 64'h0000_0000_0000_0007, a);
        idle(4);

        step(1'b1, OP_MUL, 4'd9, 64'h0000_0001_FFFF_FFFE, a);
        idle(5);

        step(1'b1, OP_ADD, 4'd1, 64'h1111_1111_0000_00A1, a);
        step(1'b1, OP_SUB, 4'd2, 64'h2222_2222_0000_00B2, a);
        step(1'b1, OP_OR,  4'd3, 64'h3333_3333_0000_00C3, a);
        idle(4);

        step(1'b1, OP_MUL, 4'd7, 64'hDEAD_BEEF_1234_5678, a);
        issue_hold(OP_ADD, 4'd12, 64'h0000_0000_0000_0042);
        idle(5);

        step(1'b1, 5'b11111, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, a);
        idle(5);

        step(1'b1, OP_DIV, 4'd4, 64'hABCD_0123_4567_89AB, a);
        idle(2);
        pulse_clear();
        idle(5);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8) op = 5'($urandom_range(3, 18));
            else op = 5'($urandom);
            r = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) r[31:0] = 32'd0;
            step(($urandom_range(0, 9) < 7), op, 4'($urandom), r, a);
        end
        idle(6);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes outstanding, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
